// File: rtl/bitnet_infer_sequencer.sv
// Sequencer that streams weight words into a BitNet engine, then issues
// one inference per accepted input vector and buffers a single result.
module bitnet_infer_sequencer #(
  parameter int NUM_LAYERS     = 2,
  parameter int ROWS_PER_LAYER = 16,
  parameter int TIMEOUT        = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load_start,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [53:0]        w_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [53:0]        in_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [2:0]  res_data,
  output logic               eng_load_weight,
  output logic [1:0]         eng_load_layer,
  output logic [3:0]         eng_load_row,
  output logic [53:0]        eng_load_data,
  input  logic               eng_load_done,
  output logic               eng_infer_start,
  output logic [53:0]        eng_input_vec,
  input  logic signed [2:0]  eng_result,
  input  logic               eng_result_valid,
  input  logic               eng_ready,
  output logic               busy,
  output logic               weights_loaded,
  output logic               err_timeout,
  output logic [15:0]        infer_count
);

  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);
  localparam logic [1:0]     LAST_LAYER = 2'(NUM_LAYERS - 1);
  localparam logic [3:0]     LAST_ROW   = 4'(ROWS_PER_LAYER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LWAIT,
    S_RUN,
    S_EXEC
  } state_t;

  state_t         state;
  logic [1:0]     layer_cnt;
  logic [3:0]     row_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           wait_expired;
  logic           last_word;

  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign last_word    = (layer_cnt == LAST_LAYER) && (row_cnt == LAST_ROW);

  // Combinational so that a full result buffer or a same-cycle reload
  // request blocks the input handshake in that very cycle.
  assign in_ready = (state == S_RUN) && eng_ready && !res_valid && !cfg_load_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      layer_cnt       <= '0;
      row_cnt         <= '0;
      wait_cnt        <= '0;
      w_ready         <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      eng_load_weight <= 1'b0;
      eng_load_layer  <= '0;
      eng_load_row    <= '0;
      eng_load_data   <= '0;
      eng_infer_start <= 1'b0;
      eng_input_vec   <= '0;
      busy            <= 1'b0;
      weights_loaded  <= 1'b0;
      err_timeout     <= 1'b0;
      infer_count     <= '0;
    end else begin
      eng_load_weight <= 1'b0;
      eng_infer_start <= 1'b0;
      if (res_valid && res_ready)
        res_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cfg_load_start) begin
            state       <= S_LOAD;
            layer_cnt   <= '0;
            row_cnt     <= '0;
            err_timeout <= 1'b0;
            w_ready     <= 1'b1;
            busy        <= 1'b1;
          end
        end

        S_LOAD: begin
          if (w_valid && w_ready) begin
            eng_load_weight <= 1'b1;
            eng_load_data   <= w_data;
            eng_load_layer  <= layer_cnt;
            eng_load_row    <= row_cnt;
            if (last_word) begin
              state    <= S_LWAIT;
              w_ready  <= 1'b0;
              wait_cnt <= '0;
            end else if (row_cnt == LAST_ROW) begin
              row_cnt   <= '0;
              layer_cnt <= layer_cnt + 2'd1;
            end else begin
              row_cnt <= row_cnt + 4'd1;
            end
          end
        end

        S_LWAIT: begin
          if (eng_load_done) begin
            state          <= S_RUN;
            weights_loaded <= 1'b1;
            busy           <= 1'b0;
          end else if (wait_expired) begin
            state       <= S_IDLE;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (cfg_load_start) begin
            state          <= S_LOAD;
            weights_loaded <= 1'b0;
            layer_cnt      <= '0;
            row_cnt        <= '0;
            err_timeout    <= 1'b0;
            w_ready        <= 1'b1;
            busy           <= 1'b1;
          end else if (in_valid && in_ready) begin
            state           <= S_EXEC;
            eng_infer_start <= 1'b1;
            eng_input_vec   <= in_data;
            wait_cnt        <= '0;
            busy            <= 1'b1;
          end
        end

        S_EXEC: begin
          if (eng_result_valid) begin
            state       <= S_RUN;
            res_valid   <= 1'b1;
            res_data    <= eng_result;
            infer_count <= infer_count + 16'd1;
            busy        <= 1'b0;
          end else if (wait_expired) begin
            state       <= S_RUN;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          w_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitnet_infer_sequencer.sv
// Directed bench for bitnet_infer_sequencer: load, inference, backpressure,
// timeout, reload collision and mid-load reset.
module tb_bitnet_infer_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_load_start;
  logic        w_valid;
  logic        w_ready;
  logic [53:0] w_data;
  logic        in_valid;
  logic        in_ready;
  logic [53:0] in_data;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_data;
  logic        eng_load_weight;
  logic [1:0]  eng_load_layer;
  logic [3:0]  eng_load_row;
  logic [53:0] eng_load_data;
  logic        eng_load_done;
  logic        eng_infer_start;
  logic [53:0] eng_input_vec;
  logic [2:0]  eng_result;
  logic        eng_result_valid;
  logic        eng_ready;
  logic        busy;
  logic        weights_loaded;
  logic        err_timeout;
  logic [15:0] infer_count;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  bitnet_infer_sequencer #(
    .NUM_LAYERS    (2),
    .ROWS_PER_LAYER(16),
    .TIMEOUT       (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_load_start  (cfg_load_start),
    .w_valid         (w_valid),
    .w_ready         (w_ready),
    .w_data          (w_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .eng_load_weight (eng_load_weight),
    .eng_load_layer  (eng_load_layer),
    .eng_load_row    (eng_load_row),
    .eng_load_data   (eng_load_data),
    .eng_load_done   (eng_load_done),
    .eng_infer_start (eng_infer_start),
    .eng_input_vec   (eng_input_vec),
    .eng_result      (eng_result),
    .eng_result_valid(eng_result_valid),
    .eng_ready       (eng_ready),
    .busy            (busy),
    .weights_loaded  (weights_loaded),
    .err_timeout     (err_timeout),
    .infer_count     (infer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (eng_load_weight) pulse_cnt <= pulse_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams n words with w_data = index and checks each resulting load pulse.
  task automatic push_words(input int n);
    int start_pulses;
    start_pulses = pulse_cnt;
    w_valid = 1'b1;
    w_data  = 54'd0;
    for (int i = 0; i < n; i++) begin
      step();
      if (i < n - 1) w_data = 54'(i + 1);
      else           w_valid = 1'b0;
      @(negedge clk);
      check_eq($sformatf("load_pulse_%0d", i), 64'(eng_load_weight), 64'd1);
      check_eq($sformatf("load_data_%0d", i),  64'(eng_load_data), 64'(i));
      check_eq($sformatf("load_layer_%0d", i), 64'(eng_load_layer), 64'(i / 16));
      check_eq($sformatf("load_row_%0d", i),   64'(eng_load_row), 64'(i % 16));
    end
    step();
    @(negedge clk);
    check_eq("load_pulse_end", 64'(eng_load_weight), 64'd0);
    check_eq("load_pulse_count", 64'(pulse_cnt - start_pulses), 64'(n));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_w_ready"}, 64'(w_ready), 64'd0);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check_eq({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check_eq({tag, "_res_data"}, 64'(res_data), 64'd0);
    check_eq({tag, "_eng_load"}, 64'({eng_load_weight, eng_load_layer, eng_load_row}), 64'd0);
    check_eq({tag, "_eng_load_data"}, 64'(eng_load_data), 64'd0);
    check_eq({tag, "_eng_infer"}, 64'(eng_infer_start), 64'd0);
    check_eq({tag, "_eng_input_vec"}, 64'(eng_input_vec), 64'd0);
    check_eq({tag, "_status"}, 64'({busy, weights_loaded, err_timeout}), 64'd0);
    check_eq({tag, "_infer_count"}, 64'(infer_count), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_load_start = 1'b0; w_valid = 1'b0; w_data = '0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b0; eng_load_done = 1'b0;
    eng_result = '0; eng_result_valid = 1'b0; eng_ready = 1'b1;
    step(); step();
    @(negedge clk);
    check_all_zero("reset");

    // Full weight load: 2 layers x 16 rows
    step(); rst = 1'b0; cfg_load_start = 1'b1;
    step(); cfg_load_start = 1'b0;
    @(negedge clk);
    check_eq("load_w_ready", 64'(w_ready), 64'd1);
    check_eq("load_busy", 64'(busy), 64'd1);
    push_words(32);
    check_eq("lwait_w_ready", 64'(w_ready), 64'd0);
    check_eq("lwait_busy", 64'(busy), 64'd1);
    check_eq("lwait_not_loaded", 64'(weights_loaded), 64'd0);
    step(); eng_load_done = 1'b1;
    step(); eng_load_done = 1'b0;
    @(negedge clk);
    check_eq("run_loaded", 64'(weights_loaded), 64'd1);
    check_eq("run_busy", 64'(busy), 64'd0);
    check_eq("run_in_ready", 64'(in_ready), 64'd1);

    // Inference returning -1 three cycles after start
    step(); in_valid = 1'b1; in_data = 54'h15;
    @(negedge clk);
    check_eq("inf_in_ready", 64'(in_ready), 64'd1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("inf_start", 64'(eng_infer_start), 64'd1);
    check_eq("inf_vec", 64'(eng_input_vec), 64'h15);
    check_eq("inf_busy", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    check_eq("inf_start_pulse", 64'(eng_infer_start), 64'd0);
    step();
    step(); eng_result_valid = 1'b1; eng_result = 3'b111;
    @(negedge clk);
    check_eq("inf_res_not_yet", 64'(res_valid), 64'd0);
    step(); eng_result_valid = 1'b0; eng_result = 3'b000;
    @(negedge clk);
    check_eq("inf_res_valid", 64'(res_valid), 64'd1);
    check_eq("inf_res_data", 64'(res_data), 64'h7);
    check_eq("inf_count", 64'(infer_count), 64'd1);
    check_eq("inf_busy_done", 64'(busy), 64'd0);

    // Backpressure: full result buffer blocks new input
    in_valid = 1'b1; in_data = 54'h2A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
      check_eq($sformatf("bp_res_data_%0d", i), 64'({res_valid, res_data}), 64'hF);
      step();
    end
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_res_held", 64'(res_valid), 64'd1);
    step(); res_ready = 1'b0;
    @(negedge clk);
    check_eq("bp_consumed", 64'(res_valid), 64'd0);
    check_eq("bp_in_ready_free", 64'(in_ready), 64'd1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_start", 64'(eng_infer_start), 64'd1);
    check_eq("bp_vec", 64'(eng_input_vec), 64'h2A);

    // No response: timeout after 8 wait cycles
    for (int i = 0; i < 7; i++) step();
    @(negedge clk);
    check_eq("to_not_yet", 64'(err_timeout), 64'd0);
    check_eq("to_busy", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    check_eq("to_err", 64'(err_timeout), 64'd1);
    check_eq("to_busy_clr", 64'(busy), 64'd0);
    check_eq("to_count", 64'(infer_count), 64'd1);
    check_eq("to_no_res", 64'(res_valid), 64'd0);
    check_eq("to_run", 64'(in_ready), 64'd1);

    // Reload request colliding with an input handshake
    step(); cfg_load_start = 1'b1; in_valid = 1'b1; in_data = 54'h33;
    @(negedge clk);
    check_eq("col_in_ready", 64'(in_ready), 64'd0);
    step(); cfg_load_start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("col_no_start", 64'(eng_infer_start), 64'd0);
    check_eq("col_unloaded", 64'(weights_loaded), 64'd0);
    check_eq("col_w_ready", 64'(w_ready), 64'd1);
    check_eq("col_err_clr", 64'(err_timeout), 64'd0);

    // Reset in the middle of a load, then restart
    push_words(5);
    check_eq("part_row", 64'(eng_load_row), 64'd4);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    step(); cfg_load_start = 1'b1;
    step(); cfg_load_start = 1'b0;
    push_words(1);
    check_eq("restart_w_ready", 64'(w_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
